// File: rtl/arb_pkg.sv
// Shared types and helpers for the burst round-robin arbiter.
package arb_pkg;

  typedef enum logic {
    StIdle = 1'b0,
    StBusy = 1'b1
  } arb_state_e;

  // Width of a requester index; never zero even for a single requester.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/burst_rr_arbiter_sva.sv
// Assertion monitor for burst_rr_arbiter: grant/ready exclusivity and proto_err behaviour.
module burst_rr_arbiter_sva
  import arb_pkg::*;
#(
  parameter int unsigned N  = 3,
  parameter int unsigned IW = idx_width(N)
) (
  input logic          clock,
  input logic          reset_n,
  input logic          busy,
  input logic [IW-1:0] sel,
  input logic [N-1:0]  req_valid,
  input logic [N-1:0]  req_ready,
  input logic [N-1:0]  grant,
  input logic          proto_err
);

  a_grant_onehot0 : assert property (@(posedge clock) disable iff (!reset_n)
    $onehot0(grant))
    else $error("grant is multi-hot: %b", grant);

  a_ready_onehot0 : assert property (@(posedge clock) disable iff (!reset_n)
    $onehot0(req_ready))
    else $error("req_ready is multi-hot: %b", req_ready);

  a_perr_on_drop : assert property (@(posedge clock) disable iff (!reset_n)
    (busy && !req_valid[sel]) |=> proto_err)
    else $error("granted valid dropped without proto_err");

  a_perr_sticky : assert property (@(posedge clock) disable iff (!reset_n)
    proto_err |=> proto_err)
    else $error("proto_err cleared without reset");

endmodule

// File: rtl/rr_pick.sv
// Round-robin pick: lowest requester above the last winner, else lowest overall.
module rr_pick
  import arb_pkg::*;
#(
  parameter int unsigned N  = 3,
  parameter int unsigned IW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic          found,
  output logic [IW-1:0] idx
);

  logic [N-1:0] masked;

  always_comb begin
    masked = '0;
    for (int i = 0; i < int'(N); i++) begin
      masked[i] = req[i] && (i > int'(last));
    end
  end

  // Descending scans so the lowest set index is the one left standing; the
  // masked scan runs last so it overrides the unmasked fallback when non-empty.
  always_comb begin
    found = |req;
    idx   = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (req[i]) idx = IW'(i);
    end
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (masked[i]) idx = IW'(i);
    end
  end

endmodule

// File: rtl/burst_rr_arbiter.sv
// Burst-granular round-robin arbiter: one requester owns the output for len+1 beats.
module burst_rr_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned N     = 3,
  parameter int unsigned BEATW = 4,
  localparam int unsigned IW   = idx_width(N)
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [N-1:0]       req_valid,
  input  logic [N*BEATW-1:0] req_len,
  output logic [N-1:0]       req_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [IW-1:0]      out_sel,
  output logic               out_last,
  output logic [N-1:0]       grant,
  output logic               proto_err
);

  arb_state_e       state_q, state_d;
  logic [N-1:0]     grant_q, grant_d;
  logic [IW-1:0]    sel_q, sel_d;
  logic [IW-1:0]    last_q, last_d;
  logic [BEATW-1:0] cnt_q, cnt_d;
  logic             perr_q, perr_d;

  logic             pick_found;
  logic [IW-1:0]    pick_idx;
  logic [BEATW-1:0] len_arr [N];

  always_comb begin
    for (int i = 0; i < int'(N); i++) begin
      len_arr[i] = req_len[i*BEATW +: BEATW];
    end
  end

  rr_pick #(
    .N  (N),
    .IW (IW)
  ) u_pick (
    .req   (req_valid),
    .last  (last_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    out_valid = 1'b0;
    out_last  = 1'b0;
    req_ready = '0;
    if (state_q == StBusy) begin
      out_valid         = req_valid[sel_q];
      out_last          = (cnt_q == '0);
      req_ready[sel_q]  = out_ready;
    end
  end

  assign grant     = grant_q;
  assign out_sel   = sel_q;
  assign proto_err = perr_q;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    perr_d  = perr_q;
    case (state_q)
      StIdle: begin
        if (pick_found) begin
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
          sel_d             = pick_idx;
          cnt_d             = len_arr[pick_idx];
          state_d           = StBusy;
        end
      end
      StBusy: begin
        // A dropped valid mid-burst is flagged but the burst keeps ownership.
        if (!req_valid[sel_q]) perr_d = 1'b1;
        if (out_valid && out_ready) begin
          if (cnt_q == '0) begin
            state_d = StIdle;
            grant_d = '0;
            last_d  = sel_q;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      grant_q <= '0;
      sel_q   <= '0;
      last_q  <= IW'(N - 1);
      cnt_q   <= '0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      perr_q  <= perr_d;
    end
  end

`ifndef SYNTHESIS
  burst_rr_arbiter_sva #(
    .N  (N),
    .IW (IW)
  ) u_sva (
    .clock     (clock),
    .reset_n   (reset_n),
    .busy      (state_q == StBusy),
    .sel       (sel_q),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .grant     (grant_q),
    .proto_err (perr_q)
  );
`endif

endmodule
